viterbi_acs: RTL and testbench
==============================

// Module: viterbi_acs
// PURPOSE
//  Hard-decision branch-metric + add-compare-select stage of the Viterbi decoder.
//  Consumes 2-bit code symbols c[1:0] from the rate-1/2, K=3 encoder (c[0]=b^d0^d1, c[1]=b^d1) after the channel.
//  Keeps 4 path metrics; per accepted symbol emits 4 survivor decision bits and the best state.
//  Output feeds the traceback/survivor memory stage.
// PARAMETERS
//  PM_W     6   path-metric width in bits (>=4)
//  PM_INIT  4   reset metric of states 1..3 (state 0 is 0); must be < 2**PM_W
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     synchronous, active-high
//  flush      in   1     sync restart of trellis (same effect as reset on metrics/outputs)
//  in_valid   in   1     cin valid this cycle
//  cin        in   2     received symbol, bit0 <-> c[0], bit1 <-> c[1]
//  dec_valid  out  1     dec/best_state/best_pm valid (1-cycle pulse per symbol)
//  dec        out  4     survivor decision per next-state, bit n for state n
//  best_state out  2     index of minimum new metric
//  best_pm    out  PM_W  minimum new metric
// BEHAVIOUR
//  State s = {d0,d1} (bit1=d0 newest, bit0=d1). Input b: next n={b,d0}; preds of n are {n[0],0},{n[0],1}.
//  Expected symbol for (s,b): {b^d1, b^d0^d1}. Branch metric = Hamming dist(cin, expected), 0..2.
//  Per n: cand0 = pm[{n[0],0}]+bm, cand1 = pm[{n[0],1}]+bm; pick smaller; tie -> cand0.
//  dec[n] = d1 of chosen pred (0 for cand0, 1 for cand1).
//  Latency: symbol sampled at edge k when in_valid=1; pm, dec, best_state, best_pm, dec_valid=1 updated at edge k.
//  in_valid=0: pm and dec/best_* hold; dec_valid=0 next cycle.
//  best_state: lowest index among equal minima.
//  Adders 1 bit wider internally; stored metrics clamp to 2**PM_W-1 (never wrap).
//  reset or flush: pm={PM_INIT,PM_INIT,PM_INIT,0} (states 3..0), dec=0, best_state=0, best_pm=0, dec_valid=0.
//  flush with in_valid same cycle: flush wins, symbol dropped. reset has priority over all.
//  Reset mid-stream: all history discarded; next valid symbol treated as first from state 0.
// CONFIGURATION
//  VITERBI_PM_NORM_EN defined: after ACS, subtract min new metric from all four before storing
//   -> best_pm always 0, metrics stay bounded, clamp never reached for noise <= 2**PM_W-3 per window.
//  Undefined: no normalisation; metrics grow and saturate at 2**PM_W-1; best_pm reports raw min.
//  dec and best_state identical in both modes until saturation occurs.
// STRUCTURE
//  viterbi_pkg: NUM_STATES=4, state typedef (2 bit), function exp_sym(state,b) returning 2-bit
//   code symbol, function hamming2(a,b) -> 2-bit metric; shared with encoder model and traceback.
//  Sub-module acs_cell: two candidate adds, compare, select, clamp; instantiated 4x.
//  Top holds pm registers, min-tree, optional normaliser, output registers.
// TESTING
//  1 reset, then in_valid=1 cin=2'b00 -> pm[0..3]=0,5,2,5 (no norm), dec=4'b0000, best_state=0, best_pm=0.
//  2 noise-free stream from encoder, b=1,0,1,1 -> best_state per symbol 2,1,2,3; best_pm=0 throughout.
//  3 same stream with cin bit0 flipped on 2nd symbol -> best_pm=1 from 2nd symbol on (no norm), dec path still
//    reconstructs b=1,0,1,1 by traceback in bench model.
//  4 64 symbols cin=2'b11 vs all-zero expectation, no norm -> no metric exceeds 2**PM_W-1, no wrap;
//    with VITERBI_PM_NORM_EN -> best_pm=0 every symbol.
//  5 in_valid pulsed every 3rd cycle -> dec_valid only on cycles following accepted symbols; outputs hold between.
//  6 flush asserted with in_valid=1 cin=2'b11 mid-stream -> symbol dropped, pm back to 0,4,4,4, dec_valid=0.

Source files
------------

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared trellis definitions for the rate-1/2, K=3 Viterbi chain.
// Used by the ACS stage, the encoder model and the traceback stage.
//   NUM_STATES : number of trellis states (4)
//   state_t    : trellis state {d0, d1}, bit1 = d0 (newest), bit0 = d1
//   exp_sym()  : code symbol {c1, c0} the encoder emits leaving state s with input b
//   hamming2() : Hamming distance between two 2-bit symbols (0..2)
package viterbi_pkg;

    localparam int unsigned NUM_STATES = 4;

    typedef logic [1:0] state_t;
    typedef logic [1:0] sym_t;
    typedef logic [1:0] bm_t;

    // c[0] = b ^ d0 ^ d1, c[1] = b ^ d1
    function automatic sym_t exp_sym(input state_t s, input logic b);
        exp_sym = {b ^ s[0], b ^ s[1] ^ s[0]};
    endfunction

    function automatic bm_t hamming2(input sym_t a, input sym_t b);
        sym_t x;
        x = a ^ b;
        hamming2 = {1'b0, x[0]} + {1'b0, x[1]};
    endfunction

endpackage

// File: rtl/viterbi_acs_if.sv
// viterbi_acs_if: symbol-in / decision-out bundle of the ACS stage.
//   flush      : synchronous trellis restart
//   in_valid   : cin valid this cycle
//   cin        : received hard-decision symbol {c1, c0}
//   dec_valid  : one-cycle pulse per accepted symbol
//   dec        : survivor decision per next-state (bit n for state n)
//   best_state : index of the minimum new metric
//   best_pm    : minimum new metric
// Modports: master drives symbols and consumes decisions, slave is the ACS stage.
interface viterbi_acs_if #(
    parameter int unsigned PM_W = 6
);
    import viterbi_pkg::*;

    logic                  flush;
    logic                  in_valid;
    sym_t                  cin;
    logic                  dec_valid;
    logic [NUM_STATES-1:0] dec;
    state_t                best_state;
    logic [PM_W-1:0]       best_pm;

    modport master (
        output flush, in_valid, cin,
        input  dec_valid, dec, best_state, best_pm
    );

    modport slave (
        input  flush, in_valid, cin,
        output dec_valid, dec, best_state, best_pm
    );

endinterface

// File: rtl/viterbi_acs_cell.sv
// acs_cell: add-compare-select for one next-state of the trellis.
//   pm0/bm0 : metric and branch metric via the predecessor with d1 = 0
//   pm1/bm1 : metric and branch metric via the predecessor with d1 = 1
//   pm_new  : selected metric, saturated at 2**PM_W-1
//   dec     : 1 when the d1 = 1 predecessor wins (ties go to d1 = 0)
module acs_cell
    import viterbi_pkg::*;
#(
    parameter int unsigned PM_W = 6
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  bm_t             bm0,
    input  bm_t             bm1,
    output logic [PM_W-1:0] pm_new,
    output logic            dec
);

    logic [PM_W:0] cand0;
    logic [PM_W:0] cand1;
    logic [PM_W:0] sel;

    // One extra bit holds any sum (max 2**PM_W+1), so the compare is exact
    // even when both candidates would clamp.
    always_comb begin
        cand0  = {1'b0, pm0} + {{(PM_W-1){1'b0}}, bm0};
        cand1  = {1'b0, pm1} + {{(PM_W-1){1'b0}}, bm1};
        dec    = (cand1 < cand0);
        sel    = dec ? cand1 : cand0;
        pm_new = sel[PM_W] ? '1 : sel[PM_W-1:0];
    end

endmodule

// File: rtl/viterbi_acs.sv
// viterbi_acs: hard-decision branch metric + add-compare-select stage.
// Holds the four path metrics, runs one trellis step per accepted symbol and
// emits the survivor decisions plus the best state / metric for traceback.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; highest priority
//   bus   : viterbi_acs_if slave (flush, in_valid, cin in; dec_valid, dec,
//           best_state, best_pm out, all registered)
// Parameters:
//   PM_W    : path-metric width (>= 4)
//   PM_INIT : restart metric of states 1..3 (state 0 restarts at 0)
// Build option VITERBI_PM_NORM_EN: subtract the minimum new metric from all
// four before storing, so best_pm reads 0 and metrics stay bounded.
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int unsigned PM_W    = 6,
    parameter int unsigned PM_INIT = 4
) (
    input logic          clk,
    input logic          reset,
    viterbi_acs_if.slave bus
);

    localparam logic [PM_W-1:0] PM_RST = PM_W'(PM_INIT);

    logic [PM_W-1:0]       pm_q [NUM_STATES];
    logic [PM_W-1:0]       pm_new [NUM_STATES];
    logic [PM_W-1:0]       pm_nxt [NUM_STATES];
    logic [NUM_STATES-1:0] dec_new;

    logic [NUM_STATES-1:0] dec_q;
    state_t                best_state_q;
    logic [PM_W-1:0]       best_pm_q;
    logic                  dec_valid_q;

    // Next state n = {b, d0}; its predecessors are {n[0], 0} and {n[0], 1}.
    for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
        localparam state_t NS = state_t'(n);
        localparam state_t P0 = {NS[0], 1'b0};
        localparam state_t P1 = {NS[0], 1'b1};

        bm_t bm0;
        bm_t bm1;

        always_comb begin
            bm0 = hamming2(bus.cin, exp_sym(P0, NS[1]));
            bm1 = hamming2(bus.cin, exp_sym(P1, NS[1]));
        end

        acs_cell #(
            .PM_W (PM_W)
        ) u_acs (
            .pm0    (pm_q[P0]),
            .pm1    (pm_q[P1]),
            .bm0    (bm0),
            .bm1    (bm1),
            .pm_new (pm_new[n]),
            .dec    (dec_new[n])
        );
    end

    // Min tree; '<' keeps the lower index on equal metrics at every level.
    logic [PM_W-1:0] m01;
    logic [PM_W-1:0] m23;
    logic [PM_W-1:0] pm_min;
    state_t          i01;
    state_t          i23;
    state_t          min_idx;

    always_comb begin
        if (pm_new[1] < pm_new[0]) begin
            m01 = pm_new[1];
            i01 = 2'd1;
        end else begin
            m01 = pm_new[0];
            i01 = 2'd0;
        end
        if (pm_new[3] < pm_new[2]) begin
            m23 = pm_new[3];
            i23 = 2'd3;
        end else begin
            m23 = pm_new[2];
            i23 = 2'd2;
        end
        if (m23 < m01) begin
            pm_min  = m23;
            min_idx = i23;
        end else begin
            pm_min  = m01;
            min_idx = i01;
        end
    end

    logic [PM_W-1:0] norm_sub;
    logic [PM_W-1:0] best_pm_d;

    always_comb begin
`ifdef VITERBI_PM_NORM_EN
        norm_sub = pm_min;
`else
        norm_sub = '0;
`endif
        pm_nxt[0] = pm_new[0] - norm_sub;
        pm_nxt[1] = pm_new[1] - norm_sub;
        pm_nxt[2] = pm_new[2] - norm_sub;
        pm_nxt[3] = pm_new[3] - norm_sub;
        best_pm_d = pm_min - norm_sub;
    end

    // flush has the same effect as reset and drops a coincident symbol.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            pm_q[0]      <= '0;
            pm_q[1]      <= PM_RST;
            pm_q[2]      <= PM_RST;
            pm_q[3]      <= PM_RST;
            dec_q        <= '0;
            best_state_q <= '0;
            best_pm_q    <= '0;
            dec_valid_q  <= 1'b0;
        end else if (bus.in_valid) begin
            pm_q[0]      <= pm_nxt[0];
            pm_q[1]      <= pm_nxt[1];
            pm_q[2]      <= pm_nxt[2];
            pm_q[3]      <= pm_nxt[3];
            dec_q        <= dec_new;
            best_state_q <= min_idx;
            best_pm_q    <= best_pm_d;
            dec_valid_q  <= 1'b1;
        end else begin
            dec_valid_q  <= 1'b0;
        end
    end

    assign bus.dec_valid  = dec_valid_q;
    assign bus.dec        = dec_q;
    assign bus.best_state = best_state_q;
    assign bus.best_pm    = best_pm_q;

endmodule

// File: tb/tb_viterbi_acs.sv
// tb_viterbi_acs: scoreboard bench for viterbi_acs. A behavioural trellis
// model pushes the expected outputs (and path metrics) for every clock edge
// that changes state; a negedge monitor pops and compares them, and checks
// that outputs hold and dec_valid stays low on cycles with nothing queued.
// Honours VITERBI_PM_NORM_EN in the same way as the design.
module tb_viterbi_acs;

    localparam int PM_W    = 6;
    localparam int PM_INIT = 4;
    localparam int PM_MAXV = (1 << PM_W) - 1;

    typedef struct packed {
        logic                 valid;
        logic [3:0]           dec;
        logic [1:0]           bs;
        logic [PM_W-1:0]      bpm;
        logic [3:0][PM_W-1:0] pm;
    } exp_t;

    logic clk;
    logic reset;

    viterbi_acs_if #(.PM_W(PM_W)) bus ();

    viterbi_acs #(
        .PM_W    (PM_W),
        .PM_INIT (PM_INIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t hold;
    bit   mon_en = 0;
    bit   rec_en = 0;
    int   rec_bs[$];
    int   rec_bpm[$];
    int   rec_dec[$];
    int   mpm[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        check("dec_valid", int'(bus.dec_valid), int'(e.valid));
        check("dec", int'(bus.dec), int'(e.dec));
        check("best_state", int'(bus.best_state), int'(e.bs));
        check("best_pm", int'(bus.best_pm), int'(e.bpm));
        check("pm0", int'(dut.pm_q[0]), int'(e.pm[0]));
        check("pm1", int'(dut.pm_q[1]), int'(e.pm[1]));
        check("pm2", int'(dut.pm_q[2]), int'(e.pm[2]));
        check("pm3", int'(dut.pm_q[3]), int'(e.pm[3]));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check_outputs(e);
                hold = e;
                hold.valid = 1'b0;
                if (rec_en && e.valid) begin
                    rec_bs.push_back(int'(bus.best_state));
                    rec_bpm.push_back(int'(bus.best_pm));
                    rec_dec.push_back(int'(bus.dec));
                end
            end else begin
                check_outputs(hold);
            end
        end
    end

    // Encoder model: state {d0, d1}, c0 = b^d0^d1, c1 = b^d1.
    function automatic logic [1:0] enc_sym(input logic [1:0] st, input logic b);
        logic d0;
        logic d1;
        d0 = st[1];
        d1 = st[0];
        return {b ^ d1, b ^ d0 ^ d1};
    endfunction

    task automatic model_edge(input logic r, input logic f, input logic v, input logic [1:0] c);
        exp_t e;
        int   newpm[$];
        int   best;
        int   cand;
        int   bm;
        int   bi;
        int   mn;
        logic dsel;
        logic [1:0] n;
        logic [1:0] p;
        logic b;
        logic d0;
        logic d1;
        logic e0;
        logic e1;
        e = '0;
        if (r || f) begin
            mpm = '{0, PM_INIT, PM_INIT, PM_INIT};
            e.pm[0] = '0;
            e.pm[1] = PM_W'(PM_INIT);
            e.pm[2] = PM_W'(PM_INIT);
            e.pm[3] = PM_W'(PM_INIT);
            sb.push_back(e);
        end else if (v) begin
            newpm = '{0, 0, 0, 0};
            for (int i = 0; i < 4; i++) begin
                n    = i[1:0];
                b    = n[1];
                d0   = n[0];
                best = 0;
                dsel = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    d1   = j[0];
                    p    = {d0, d1};
                    e1   = b ^ d1;
                    e0   = b ^ d0 ^ d1;
                    bm   = int'(c[0] != e0) + int'(c[1] != e1);
                    cand = mpm[p] + bm;
                    if (j == 0 || cand < best) begin
                        best = cand;
                        dsel = d1;
                    end
                end
                if (best > PM_MAXV) best = PM_MAXV;
                newpm[i]  = best;
                e.dec[n]  = dsel;
            end
            bi = 0;
            for (int i = 1; i < 4; i++) if (newpm[i] < newpm[bi]) bi = i;
            mn = newpm[bi];
`ifdef VITERBI_PM_NORM_EN
            for (int i = 0; i < 4; i++) newpm[i] = newpm[i] - mn;
            e.bpm = '0;
`else
            e.bpm = PM_W'(mn);
`endif
            for (int i = 0; i < 4; i++) begin
                n        = i[1:0];
                mpm[i]   = newpm[i];
                e.pm[n]  = PM_W'(newpm[i]);
            end
            e.bs    = 2'(bi);
            e.valid = 1'b1;
            sb.push_back(e);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic v, input logic [1:0] c);
        reset        = r;
        bus.flush    = f;
        bus.in_valid = v;
        bus.cin      = c;
        @(posedge clk);
        model_edge(r, f, v, c);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'(urand4()));
    endtask

    function automatic int urand4();
        return int'($urandom_range(0, 3));
    endfunction

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] st;
        logic [1:0] s;
        logic [1:0] c;
        logic [3:0] dv;
        int         bits[$];
        int         exp_bs[$];

        bits   = '{1, 0, 1, 1};
        exp_bs = '{2, 1, 2, 3};
        hold   = '0;

        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.cin      = 2'b00;
        mon_en       = 1'b1;
        step(1'b1, 1'b0, 1'b0, 2'b00);
        idle();

        // First symbol 00 from the reset trellis.
        step(1'b0, 1'b0, 1'b1, 2'b00);
        idle();

        // Noise-free encoded stream b = 1,0,1,1.
        step(1'b1, 1'b0, 1'b0, 2'b00);
        rec_en = 1'b1;
        st = 2'b00;
        for (int k = 0; k < 4; k++) begin
            c  = enc_sym(st, bits[k][0]);
            st = {bits[k][0], st[1]};
            step(1'b0, 1'b0, 1'b1, c);
        end
        settle();
        rec_en = 1'b0;
        check("t2_count", rec_bs.size(), 4);
        for (int k = 0; k < 4 && k < rec_bs.size(); k++) begin
            check("t2_best_state", rec_bs[k], exp_bs[k]);
            check("t2_best_pm", rec_bpm[k], 0);
        end

        // Same stream with c[0] of the second symbol flipped, then traceback.
        rec_bs.delete();
        rec_bpm.delete();
        rec_dec.delete();
        step(1'b1, 1'b0, 1'b0, 2'b00);
        rec_en = 1'b1;
        st = 2'b00;
        for (int k = 0; k < 4; k++) begin
            c  = enc_sym(st, bits[k][0]);
            st = {bits[k][0], st[1]};
            if (k == 1) c[0] = ~c[0];
            step(1'b0, 1'b0, 1'b1, c);
        end
        settle();
        rec_en = 1'b0;
        check("t3_count", rec_bs.size(), 4);
        if (rec_bs.size() == 4) begin
            check("t3_best_pm0", rec_bpm[0], 0);
`ifdef VITERBI_PM_NORM_EN
            for (int k = 1; k < 4; k++) check("t3_best_pm", rec_bpm[k], 0);
`else
            for (int k = 1; k < 4; k++) check("t3_best_pm", rec_bpm[k], 1);
`endif
            s = 2'(rec_bs[3]);
            for (int k = 3; k >= 0; k--) begin
                dv = 4'(rec_dec[k]);
                check("t3_traceback_bit", int'(s[1]), bits[k]);
                s = {s[0], dv[s]};
            end
            check("t3_traceback_origin", int'(s), 0);
        end

        // Long run against the all-zero path: metrics saturate, never wrap.
        step(1'b1, 1'b0, 1'b0, 2'b00);
        for (int k = 0; k < 64; k++) step(1'b0, 1'b0, 1'b1, 2'b11);
        idle();

        // in_valid every third cycle, random symbols.
        step(1'b1, 1'b0, 1'b0, 2'b00);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 1'b1, 2'(urand4()));
            idle();
            idle();
        end

        // Flush with a coincident valid symbol mid-stream.
        step(1'b0, 1'b1, 1'b1, 2'b11);
        idle();
        step(1'b0, 1'b0, 1'b1, 2'b01);
        step(1'b0, 1'b0, 1'b1, 2'b10);

        // Reset beats flush and in_valid; next symbol starts from state 0.
        step(1'b1, 1'b1, 1'b1, 2'b11);
        step(1'b0, 1'b0, 1'b1, 2'b11);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b1, 2'(urand4()));
        idle();
        idle();
        settle();

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
